// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button synchronizers and debouncers, IDLE/RUN/PAUSE
// state machine and the single-cycle 1 Hz advance pulse generator.
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       count_1hz,
    output logic       running,
    output logic       clear,
    output logic [1:0] state
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int DW = $clog2(DB_CYCLES + 1);

    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] P_PRE  = PW'(CLK_HZ - 2);
    localparam logic [DW-1:0] D_LAST = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } st_t;

    // Bit 0 is start/stop, bit 1 is clear.
    logic [1:0]         raw;
    logic [1:0]         s1;
    logic [1:0]         s2;
    logic [1:0]         db;
    logic [1:0]         db_q;
    logic [1:0][DW-1:0] cnt;
    logic [1:0]         press;
    logic               ss_ev;
    logic               clr_ev;

    st_t                cur;
    st_t                nxt;
    logic               clr_go;
    logic [PW-1:0]      presc;

    assign raw    = {btn_clear, btn_start_stop};
    assign press  = db & ~db_q;
    assign ss_ev  = press[0];
    assign clr_ev = press[1];
    assign state  = cur;

    // Synchronize, debounce and keep a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            cnt  <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == D_LAST) begin
                    cnt[i] <= '0;
                    db[i]  <= s2[i];
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end

    // Next state from press events; clear has priority outside RUN
    always_comb begin
        nxt    = cur;
        clr_go = 1'b0;
        case (cur)
            S_IDLE: begin
                if (clr_ev)
                    clr_go = 1'b1;
                else if (ss_ev)
                    nxt = S_RUN;
            end
            S_RUN: begin
                if (ss_ev)
                    nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (clr_ev) begin
                    nxt    = S_IDLE;
                    clr_go = 1'b1;
                end else if (ss_ev) begin
                    nxt = S_RUN;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // State register, registered outputs and RUN-gated prescaler
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= S_IDLE;
            running   <= 1'b0;
            clear     <= 1'b0;
            count_1hz <= 1'b0;
            presc     <= '0;
        end else begin
            cur       <= nxt;
            running   <= (nxt == S_RUN);
            clear     <= clr_go;
            // Tick is high during the cycle the prescaler sits at its last value
            count_1hz <= (cur == S_RUN) && (presc == P_PRE);
            if (nxt == S_IDLE)
                presc <= '0;
            else if (cur == S_RUN)
                presc <= (presc == P_LAST) ? '0 : presc + PW'(1);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus randomized button traffic,
// every cycle compared against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ = 10;
    localparam int DB     = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn_ss  = 1'b0;
    logic       btn_clr = 1'b0;
    logic       count_1hz;
    logic       running;
    logic       clear;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int       m_state;
    int       m_runs;
    bit       m_run;
    bit       m_clr;
    bit       m_tick;
    bit [1:0] m_s1;
    bit [1:0] m_s2;
    bit [1:0] m_db;
    bit [1:0] m_dbq;
    bit       hist [2][DB];
    int       hlen [2];

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .DB_CYCLES(DB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start_stop(btn_ss),
        .btn_clear     (btn_clr),
        .count_1hz     (count_1hz),
        .running       (running),
        .clear         (clear),
        .state         (state)
    );

    // Advance one clock: update the model at the edge, compare at the falling edge
    task automatic step();
        bit pss;
        bit pcl;
        bit was_run;
        bit diff;
        @(posedge clk);
        if (!rst_n) begin
            m_state = 0;
            m_runs  = 0;
            m_run   = 1'b0;
            m_clr   = 1'b0;
            m_tick  = 1'b0;
            m_s1    = '0;
            m_s2    = '0;
            m_db    = '0;
            m_dbq   = '0;
            hlen[0] = 0;
            hlen[1] = 0;
        end else begin
            pss     = m_db[0] && !m_dbq[0];
            pcl     = m_db[1] && !m_dbq[1];
            was_run = (m_state == 1);
            if (was_run)
                m_runs++;
            m_tick = was_run && ((m_runs % CLK_HZ) == CLK_HZ - 1);
            m_clr  = 1'b0;
            case (m_state)
                0: begin
                    if (pcl) m_clr = 1'b1;
                    else if (pss) m_state = 1;
                end
                1: begin
                    if (pss) m_state = 2;
                end
                default: begin
                    if (pcl) begin
                        m_state = 0;
                        m_clr   = 1'b1;
                    end else if (pss) begin
                        m_state = 1;
                    end
                end
            endcase
            if (m_state == 0)
                m_runs = 0;
            m_run = (m_state == 1);
            m_dbq = m_db;
            // A level is accepted once the last DB synced samples all disagree
            for (int b = 0; b < 2; b++) begin
                for (int i = DB - 1; i > 0; i--)
                    hist[b][i] = hist[b][i-1];
                hist[b][0] = m_s2[b];
                if (hlen[b] < DB)
                    hlen[b]++;
                diff = (hlen[b] == DB);
                for (int i = 0; i < DB; i++)
                    if (hist[b][i] == m_db[b])
                        diff = 1'b0;
                if (diff)
                    m_db[b] = ~m_db[b];
            end
            m_s2 = m_s1;
            m_s1 = {btn_clr, btn_ss};
        end
        @(negedge clk);
        if (chk_en) begin
            n_cmp++;
            if (state !== 2'(m_state)) begin
                n_bad++;
                $display("FAIL model_state t=%0t: got %0d want %0d", $time, state, m_state);
            end
            n_cmp++;
            if (running !== m_run) begin
                n_bad++;
                $display("FAIL model_running t=%0t: got %0b want %0b", $time, running, m_run);
            end
            n_cmp++;
            if (clear !== m_clr) begin
                n_bad++;
                $display("FAIL model_clear t=%0t: got %0b want %0b", $time, clear, m_clr);
            end
            n_cmp++;
            if (count_1hz !== m_tick) begin
                n_bad++;
                $display("FAIL model_tick t=%0t: got %0b want %0b", $time, count_1hz, m_tick);
            end
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int r;
        rst_n   = 1'b0;
        btn_ss  = 1'b1;
        btn_clr = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (state !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        n_cmp++;
        if ({running, clear, count_1hz} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %03b want 000", {running, clear, count_1hz});
        end
        rst_n   = 1'b1;
        btn_clr = 1'b0;
        r = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (running && r == 0)
                r = k;
        end
        n_cmp++;
        if (r != 7) begin
            n_bad++;
            $display("FAIL reset_start_latency: got edge %0d want 7", r);
        end
        btn_ss = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_start_ticks();
        int r;
        int dbl;
        int bad_st;
        bit prev;
        int tq[$];
        do_reset();
        btn_ss = 1'b1;
        r      = 0;
        dbl    = 0;
        bad_st = 0;
        prev   = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 20)
                btn_ss = 1'b0;
            if (running && r == 0)
                r = k;
            if (count_1hz)
                tq.push_back(k);
            if (count_1hz && prev)
                dbl++;
            prev = count_1hz;
            if (k >= 7 && state !== 2'b01)
                bad_st++;
        end
        n_cmp++;
        if (r != 7) begin
            n_bad++;
            $display("FAIL start_latency: got edge %0d want 7", r);
        end
        n_cmp++;
        if (tq.size() != 3) begin
            n_bad++;
            $display("FAIL tick_count: got %0d want 3", tq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (tq[i] != 16 + 10 * i) begin
                    n_bad++;
                    $display("FAIL tick_edge%0d: got %0d want %0d", i, tq[i], 16 + 10 * i);
                end
            end
        end
        n_cmp++;
        if (dbl != 0) begin
            n_bad++;
            $display("FAIL tick_width: got %0d double pulses want 0", dbl);
        end
        n_cmp++;
        if (bad_st != 0) begin
            n_bad++;
            $display("FAIL run_state: got %0d off-RUN cycles want 0", bad_st);
        end
    endtask

    task automatic test_glitch();
        int bad;
        int ncl;
        do_reset();
        bad = 0;
        ncl = 0;
        btn_ss = 1'b1;
        repeat (3) step();
        btn_ss = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (state !== 2'b00 || running)
                bad++;
        end
        btn_clr = 1'b1;
        repeat (3) step();
        btn_clr = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (clear)
                ncl++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL glitch_start: got %0d state changes want 0", bad);
        end
        n_cmp++;
        if (ncl != 0) begin
            n_bad++;
            $display("FAIL glitch_clear: got %0d clear pulses want 0", ncl);
        end
    endtask

    task automatic test_pause();
        int found;
        int ticks;
        int bad;
        int r;
        int t;
        do_reset();
        btn_ss = 1'b1;
        repeat (10) step();
        btn_ss = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step();
            if (count_1hz)
                found = 1;
        end
        n_cmp++;
        if (found == 0) begin
            n_bad++;
            $display("FAIL pause_first_tick: got none want a tick within 30 cycles");
        end
        // Stop edge lands after five RUN cycles past a tick, leaving the fraction at 5
        repeat (9) step();
        btn_ss = 1'b1;
        repeat (7) step();
        n_cmp++;
        if (state !== 2'b10 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_enter: got state %0d run %0b want 2/0", state, running);
        end
        repeat (5) step();
        btn_ss = 1'b0;
        ticks = 0;
        bad   = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (count_1hz)
                ticks++;
            if (state !== 2'b10)
                bad++;
        end
        n_cmp++;
        if (ticks != 0 || bad != 0) begin
            n_bad++;
            $display("FAIL pause_hold: got %0d ticks %0d bad states want 0/0", ticks, bad);
        end
        btn_ss = 1'b1;
        r = 0;
        t = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 10)
                btn_ss = 1'b0;
            if (running && r == 0)
                r = k;
            if (count_1hz && t == 0)
                t = k;
        end
        n_cmp++;
        if (r != 7 || t != r + 4) begin
            n_bad++;
            $display("FAIL resume_tick: got run %0d tick %0d want 7/11", r, t);
        end
    endtask

    task automatic test_clear();
        int ticks;
        int ncl;
        int bad;
        int ce;
        int ie;
        int r;
        int t;
        ticks = 0;
        ncl   = 0;
        bad   = 0;
        btn_clr = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 8)
                btn_clr = 1'b0;
            if (count_1hz)
                ticks++;
            if (clear)
                ncl++;
            if (state !== 2'b01)
                bad++;
        end
        n_cmp++;
        if (ticks != 3 || ncl != 0 || bad != 0) begin
            n_bad++;
            $display("FAIL clear_in_run: got ticks %0d clr %0d bad %0d want 3/0/0", ticks, ncl, bad);
        end
        btn_ss = 1'b1;
        repeat (12) step();
        btn_ss = 1'b0;
        repeat (10) step();
        n_cmp++;
        if (state !== 2'b10) begin
            n_bad++;
            $display("FAIL clear_setup_pause: got %0d want 2", state);
        end
        ncl = 0;
        ce  = 0;
        ie  = 0;
        btn_clr = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 8)
                btn_clr = 1'b0;
            if (clear) begin
                ncl++;
                if (ce == 0)
                    ce = k;
            end
            if (state === 2'b00 && ie == 0)
                ie = k;
        end
        n_cmp++;
        if (ncl != 1 || ce != 7 || ie != 7) begin
            n_bad++;
            $display("FAIL clear_in_pause: got n %0d edge %0d idle %0d want 1/7/7", ncl, ce, ie);
        end
        btn_ss = 1'b1;
        r = 0;
        t = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 10)
                btn_ss = 1'b0;
            if (running && r == 0)
                r = k;
            if (count_1hz && t == 0)
                t = k;
        end
        n_cmp++;
        if (r != 7 || t != r + 9) begin
            n_bad++;
            $display("FAIL clear_restart_tick: got run %0d tick %0d want 7/16", r, t);
        end
    endtask

    task automatic test_simul();
        int ncl;
        ncl = 0;
        btn_ss  = 1'b1;
        btn_clr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 10) begin
                btn_ss  = 1'b0;
                btn_clr = 1'b0;
            end
            if (clear)
                ncl++;
        end
        n_cmp++;
        if (state !== 2'b10 || ncl != 0) begin
            n_bad++;
            $display("FAIL simul_run: got state %0d clr %0d want 2/0", state, ncl);
        end
        ncl = 0;
        btn_ss  = 1'b1;
        btn_clr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 10) begin
                btn_ss  = 1'b0;
                btn_clr = 1'b0;
            end
            if (clear)
                ncl++;
        end
        n_cmp++;
        if (state !== 2'b00 || ncl != 1) begin
            n_bad++;
            $display("FAIL simul_pause: got state %0d clr %0d want 0/1", state, ncl);
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 250; seg++) begin
            if ($urandom_range(0, 30) == 0) begin
                rst_n = 1'b0;
                len   = $urandom_range(1, 2);
            end else begin
                rst_n   = 1'b1;
                btn_ss  = ($urandom_range(0, 1) == 1);
                btn_clr = ($urandom_range(0, 2) == 0);
                len     = $urandom_range(1, 14);
            end
            repeat (len) step();
        end
        rst_n   = 1'b1;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        chk_en = 1'b1;
        test_reset();
        test_start_ticks();
        test_glitch();
        test_pause();
        test_clear();
        test_simul();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
